// File: rtl/bist_response_analyzer.sv
// BIST response analyzer for the 256x4b SRAM march.
// Follows each read issued by the address/phase counter through the SRAM
// read latency, compares the returned word with the phase background and
// keeps sticky fail state, a saturating fail count and first-fail
// diagnostics. It reports done/pass once the last read of phase 1 is checked.
module bist_response_analyzer #(
  parameter int                  ADDR_W       = 8,
  parameter int                  DATA_W       = 4,
  parameter int                  READ_LATENCY = 1,
  parameter logic [DATA_W-1:0]   PAT0         = DATA_W'(0),
  parameter logic [DATA_W-1:0]   PAT1         = DATA_W'(1),
  parameter int                  CNT_W        = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              we_in,
  input  logic [3:0]        msb_in,
  input  logic [DATA_W-1:0] sram_dout,
  output logic              err_pulse,
  output logic              fail,
  output logic [CNT_W-1:0]  fail_count,
  output logic              first_fail_valid,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic              first_fail_phase,
  output logic [DATA_W-1:0] first_fail_data,
  output logic              done,
  output logic              pass
);

  // tag = {valid, addr, phase, last}
  localparam int TAG_W = ADDR_W + 3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic                w_run, w_done;

  // Depth 0 holds the tag sampled on the same edge the SRAM samples the
  // address; depth READ_LATENCY lines up with the returned sram_dout.
  logic [TAG_W-1:0]    r_pipe [0:READ_LATENCY];
  logic [TAG_W-1:0]    w_tag_in;

  logic                w_cmp_vld, w_cmp_ph, w_cmp_last;
  logic [ADDR_W-1:0]   w_cmp_addr;
  logic [DATA_W-1:0]   w_exp;
  logic                w_mis, w_fin;

  logic                r_err, r_fail, r_ffv, r_ffph;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_ffa;
  logic [DATA_W-1:0]   r_ffd;

  // Only the phase bit of the counter MSBs matters here.
  logic                w_unused;
  assign w_unused = ^msb_in[3:1];

  // Reads only enter the pipe while running; writes push a bubble.
  assign w_tag_in = {w_run & ~we_in, addr_in, msb_in[0],
                     (addr_in == {ADDR_W{1'b1}}) & msb_in[0]};

  assign {w_cmp_vld, w_cmp_addr, w_cmp_ph, w_cmp_last} = r_pipe[READ_LATENCY];
  assign w_exp = w_cmp_ph ? PAT1 : PAT0;
  // Gating by w_run freezes everything once DONE is reached.
  assign w_mis = w_run & w_cmp_vld & (sram_dout != w_exp);
  assign w_fin = w_run & w_cmp_vld & w_cmp_last;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state: first write starts the run, last checked read ends it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (we_in) w_state_nxt = S_RUN;
      S_RUN:   if (w_fin) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_run  = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_RUN:   w_run  = 1'b1;
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  // Read-tag shift pipe tracking the SRAM latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= READ_LATENCY; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_tag_in;
      for (int i = 1; i <= READ_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  // Fail accumulation and first-fail capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err  <= 1'b0;
      r_fail <= 1'b0;
      r_cnt  <= '0;
      r_ffv  <= 1'b0;
      r_ffa  <= '0;
      r_ffph <= 1'b0;
      r_ffd  <= '0;
    end else begin
      r_err <= w_mis;
      if (w_mis) begin
        r_fail <= 1'b1;
        if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_W'(1);
        if (!r_ffv) begin
          r_ffv  <= 1'b1;
          r_ffa  <= w_cmp_addr;
          r_ffph <= w_cmp_ph;
          r_ffd  <= sram_dout;
        end
      end
    end
  end

  assign err_pulse        = r_err;
  assign fail             = r_fail;
  assign fail_count       = r_cnt;
  assign first_fail_valid = r_ffv;
  assign first_fail_addr  = r_ffa;
  assign first_fail_phase = r_ffph;
  assign first_fail_data  = r_ffd;
  assign done             = w_done;
  assign pass             = w_done & ~r_fail;

endmodule
